sys_ram_dma: RTL and testbench

Parametrised successor to the CPU system RAM. It provides a single-clock synchronous RAM with bus-window mirroring and a registered CPU read/write port. It adds a page-streaming DMA read engine that feeds OAM DMA: it reads 2^PAGE_W consecutive bytes from one RAM page and hands them downstream over a valid/ready handshake. The block sits on the CPU bus at $0000-$1FFF and on the PPU OAM DMA path.

---
 rtl/sys_ram_pkg.sv | 17 +
 rtl/sys_ram_core.sv | 25 ++
 rtl/sys_ram_dma.sv | 127 ++++++++++++
 tb/tb_sys_ram_dma.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ram_pkg.sv
// Shared types and defaults for the system RAM with OAM DMA streaming.
// Imported by the RAM core and the top.
package sys_ram_pkg;

  localparam int SYS_RAM_DATA_W     = 8;
  localparam int SYS_RAM_ADDR_W     = 11;
  localparam int SYS_RAM_BUS_ADDR_W = 13;
  localparam int OAM_DMA_PAGE_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } dma_state_t;

endpackage

// File: rtl/sys_ram_core.sv
// Single-port RAM: synchronous write, read value sampled by the owner's
// register on the same edge, so a same-cycle read sees the old word.
module sys_ram_core
  import sys_ram_pkg::*;
#(
  parameter int DATA_W = SYS_RAM_DATA_W,
  parameter int ADDR_W = SYS_RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sys_ram_dma.sv
// CPU system RAM with bus mirroring plus a page-streaming DMA reader
// that hands one page to the OAM path over valid/ready.
module sys_ram_dma
  import sys_ram_pkg::*;
#(
  parameter int DATA_W     = SYS_RAM_DATA_W,
  parameter int ADDR_W     = SYS_RAM_ADDR_W,
  parameter int BUS_ADDR_W = SYS_RAM_BUS_ADDR_W,
  parameter int PAGE_W     = OAM_DMA_PAGE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [BUS_ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]        cpu_data_in,
  input  logic                     cpu_wren,
  input  logic                     cpu_rden,
  output logic [DATA_W-1:0]        cpu_data_out,
  output logic                     cpu_stall,
  input  logic                     dma_start,
  input  logic [ADDR_W-PAGE_W-1:0] dma_page,
  output logic                     dma_busy,
  output logic [DATA_W-1:0]        dma_data,
  output logic [PAGE_W-1:0]        dma_idx,
  output logic                     dma_valid,
  input  logic                     dma_ready,
  output logic                     dma_done
);

  localparam int PG_W = ADDR_W - PAGE_W;

  dma_state_t        state_q;
  logic [PG_W-1:0]   page_q;
  logic [PAGE_W-1:0] idx_q;
  logic [DATA_W-1:0] dma_data_q;
  logic [DATA_W-1:0] cpu_data_out_d;
  logic [DATA_W-1:0] cpu_data_out_q;

  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_bus_bits;

  // Upper bus bits only select the mirror, so they are dropped.
  assign unused_bus_bits = ^cpu_addr[BUS_ADDR_W-1:ADDR_W];

  assign busy = (state_q != IDLE);

  // DMA owns the RAM whenever it is not idle; CPU is shut out.
  always_comb begin
    ram_addr = cpu_addr[ADDR_W-1:0];
    ram_we   = cpu_wren;
    if (busy) begin
      ram_addr = {page_q, idx_q};
      ram_we   = 1'b0;
    end
  end

  sys_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cpu_data_in),
    .rdata (ram_rdata)
  );

  // CPU read data holds unless a non-stalled read is issued.
  always_comb begin
    cpu_data_out_d = cpu_data_out_q;
    if (!busy && cpu_rden) cpu_data_out_d = ram_rdata;
  end

  // CPU read-data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_data_out_q <= '0;
    else          cpu_data_out_q <= cpu_data_out_d;
  end

  // Burst sequencer: fetch one byte, offer it, step the page offset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      page_q     <= '0;
      idx_q      <= '0;
      dma_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dma_start) begin
            page_q  <= dma_page;
            idx_q   <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          dma_data_q <= ram_rdata;
          state_q    <= SEND;
        end
        SEND: begin
          if (dma_ready) begin
            if (&idx_q) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + PAGE_W'(1);
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign cpu_stall    = busy;
  assign dma_busy     = busy;
  assign dma_data     = dma_data_q;
  assign dma_idx      = idx_q;
  assign dma_valid    = (state_q == SEND);
  assign dma_done     = (state_q == DONE);

endmodule

// File: tb/tb_sys_ram_dma.sv
// Bench for sys_ram_dma: vector table, random CPU traffic against an
// array model, and DMA burst sequences.
module tb_sys_ram_dma;

  logic        clk;
  logic        reset_n;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [7:0]  cpu_data_out;
  logic        cpu_stall;
  logic        dma_start;
  logic [2:0]  dma_page;
  logic        dma_busy;
  logic [7:0]  dma_data;
  logic [7:0]  dma_idx;
  logic        dma_valid;
  logic        dma_ready;
  logic        dma_done;

  sys_ram_dma dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_wren     (cpu_wren),
    .cpu_rden     (cpu_rden),
    .cpu_data_out (cpu_data_out),
    .cpu_stall    (cpu_stall),
    .dma_start    (dma_start),
    .dma_page     (dma_page),
    .dma_busy     (dma_busy),
    .dma_data     (dma_data),
    .dma_idx      (dma_idx),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .dma_done     (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nmis;
  logic [7:0] ref_mem [0:2047];
  logic [7:0] ref_out;
  logic [27:0] outs;

  assign outs = {cpu_data_out, cpu_stall, dma_busy, dma_data,
                 dma_idx, dma_valid, dma_done};

  typedef struct {
    bit          wr;
    bit          rd;
    logic [12:0] a;
    logic [7:0]  d;
    bit          chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cpu_op(input bit wr, input bit rd,
                        input logic [12:0] a, input logic [7:0] d);
    cpu_wren = wr;
    cpu_rden = rd;
    cpu_addr = a;
    cpu_data_in = d;
    @(posedge clk);
    #1;
    if (rd) ref_out = ref_mem[a[10:0]];
    if (wr) ref_mem[a[10:0]] = d;
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
  endtask

  task automatic burst(input int page, input int bp_at, input bit stall,
                       input int rst_at, input bit rnd);
    int nxf;
    int ndone;
    int done_k;
    int bp_left;
    bit bp_done;
    bit aborted;
    logic [7:0] hd;
    logic [7:0] hi;
    logic [7:0] held;
    nxf = 0; ndone = 0; done_k = 0; bp_left = 0;
    bp_done = 0; aborted = 0; hd = '0; hi = '0;
    held = ref_out;
    dma_page = 3'(page);
    dma_start = 1'b1;
    dma_ready = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_at_start", dma_busy, 0);
      if (k == 2) chk("busy_stall_rise", {dma_busy, cpu_stall}, 2'b11);
      if (rst_at >= 0 && dma_valid && dma_idx == 8'(rst_at)) begin
        reset_n = 1'b0;
        #1;
        chk("reset_outs_zero", outs, 0);
        aborted = 1;
        break;
      end
      if (bp_left > 0) begin
        chk("bp_hold", {dma_valid, dma_idx, dma_data}, {1'b1, hi, hd});
        bp_left--;
        if (bp_left == 0) dma_ready = 1'b1;
      end else if (bp_at >= 0 && !bp_done && dma_valid &&
                   dma_idx == 8'(bp_at)) begin
        dma_ready = 1'b0;
        bp_left = 5;
        bp_done = 1;
        hi = dma_idx;
        hd = dma_data;
      end
      if (dma_valid && dma_ready) begin
        chk("dma_idx", dma_idx, nxf[7:0]);
        chk("dma_data", dma_data, ref_mem[page*256 + nxf]);
        nxf++;
      end
      if (dma_done) begin
        ndone++;
        if (ndone == 1) done_k = k;
      end
      if (stall && k == 10) chk("stall_high", cpu_stall, 1);
      if (stall && k == 11) chk("stall_rd_hold", cpu_data_out, held);
      if (done_k != 0 && k == done_k + 1) begin
        chk("end_idle", {dma_busy, cpu_stall, dma_valid, dma_done}, 0);
        break;
      end
      @(posedge clk);
      #1;
      dma_start = 1'b0;
      cpu_wren = 1'b0;
      cpu_rden = 1'b0;
      if (stall && k == 9) begin
        cpu_wren = 1'b1;
        cpu_rden = 1'b1;
        cpu_addr = 13'h0205;
        cpu_data_in = 8'hFF;
        dma_start = 1'b1;
      end
      if (rnd) dma_ready = 1'($urandom);
    end
    dma_start = 1'b0;
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
    if (aborted) begin
      chk("no_done_on_abort", ndone, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_held_zero", outs, 0);
      reset_n = 1'b1;
      ref_out = 8'h00;
    end else begin
      chk("xfer_count", nxf, 256);
      chk("done_count", ndone, 1);
      if (!rnd) chk("done_cycle", done_k, (bp_at >= 0) ? 519 : 514);
    end
    dma_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nmis = 0;
    ref_out = 8'h00;
    tbl[0]  = '{1, 0, 13'h0003, 8'h5A, 0, 8'h00};
    tbl[1]  = '{0, 1, 13'h0803, 8'h00, 1, 8'h5A};
    tbl[2]  = '{0, 1, 13'h1003, 8'h00, 1, 8'h5A};
    tbl[3]  = '{0, 1, 13'h1803, 8'h00, 1, 8'h5A};
    tbl[4]  = '{1, 0, 13'h0010, 8'h11, 1, 8'h5A};
    tbl[5]  = '{1, 1, 13'h0010, 8'h22, 1, 8'h11};
    tbl[6]  = '{0, 1, 13'h0010, 8'h00, 1, 8'h22};
    tbl[7]  = '{0, 1, 13'h0810, 8'h00, 1, 8'h22};
    tbl[8]  = '{1, 0, 13'h1FFF, 8'h3C, 1, 8'h22};
    tbl[9]  = '{0, 1, 13'h07FF, 8'h00, 1, 8'h3C};
    tbl[10] = '{1, 0, 13'h0800, 8'hC3, 1, 8'h3C};
    tbl[11] = '{0, 1, 13'h0000, 8'h00, 1, 8'hC3};

    reset_n = 1'b0;
    cpu_addr = '0;
    cpu_data_in = '0;
    cpu_wren = 1'b0;
    cpu_rden = 1'b0;
    dma_start = 1'b0;
    dma_page = '0;
    dma_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2048; i++)
      cpu_op(1, 0, 13'(i), 8'($urandom));

    for (int i = 0; i < 12; i++) begin
      cpu_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
      if (tbl[i].chk) chk($sformatf("table_%0d", i), cpu_data_out, tbl[i].exp);
    end

    for (int i = 0; i < 300; i++) begin
      cpu_op(1'($urandom), 1'($urandom), 13'($urandom), 8'($urandom));
      chk("rand_cpu", cpu_data_out, ref_out);
    end

    for (int i = 0; i < 256; i++)
      cpu_op(1, 0, 13'(12'h200 + i), 8'(i) ^ 8'hA5);

    burst(2, -1, 0, -1, 0);
    burst(2, 7, 0, -1, 0);
    burst(2, -1, 1, -1, 0);
    cpu_op(0, 1, 13'h0205, 8'h00);
    chk("stall_mem_kept", cpu_data_out, 8'hA0);
    burst(3, -1, 0, 100, 0);
    burst(5, -1, 0, -1, 0);
    burst(int'($urandom_range(0, 7)), -1, 0, -1, 1);
    cpu_op(0, 1, 13'h1A05, 8'h00);
    chk("post_dma_read", cpu_data_out, ref_out);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
